// File: rtl/isqrt_if.sv
// isqrt_if: argument/result bundle between a caller and isqrt_pipe; rem exists only with ISQRT_REM_EN.
interface isqrt_if #(parameter int WIDTH = 32);
  logic                 x_vld;
  logic [WIDTH-1:0]     x;
  logic                 y_vld;
  logic [WIDTH/2-1:0]   y;
  logic                 busy;
`ifdef ISQRT_REM_EN
  logic [WIDTH/2:0]     rem;
  modport master (output x_vld, x, input y_vld, y, busy, rem);
  modport slave  (input x_vld, x, output y_vld, y, busy, rem);
`else
  modport master (output x_vld, x, input y_vld, y, busy);
  modport slave  (input x_vld, x, output y_vld, y, busy);
`endif
endinterface

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined floor(sqrt(x)), one root bit per stage, latency WIDTH/2.
// Optional remainder output x - y*y enabled by defining ISQRT_REM_EN.
module isqrt_pipe #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  isqrt_if.slave  bus
);
  localparam int H      = WIDTH / 2;
  localparam int STAGES = WIDTH / 2;
  localparam int CW     = $clog2(STAGES + 1);

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vin;
  logic [H-1:0]      root_q [STAGES];
  logic [H-1:0]      root_in [STAGES];
  logic [H-1:0]      root_d [STAGES];
  logic [H+1:0]      rem_q [STAGES];
  logic [H+1:0]      rem_in [STAGES];
  logic [H+1:0]      rem_d [STAGES];
  logic [WIDTH-1:0]  xr_q [STAGES];
  logic [WIDTH-1:0]  xr_in [STAGES];
  logic [WIDTH-1:0]  xr_d [STAGES];
  logic [H+1:0]      r, t;
  logic              ge;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ret;

  // remainder stays below 2*root, so dropping its top two bits before the shift loses nothing
  always_comb begin
    r = '0;
    t = '0;
    ge = 1'b0;
    vin = {vld_q[STAGES-2:0], bus.x_vld};
    root_in[0] = '0;
    rem_in[0] = '0;
    xr_in[0] = bus.x;
    for (int i = 1; i < STAGES; i++) begin
      root_in[i] = root_q[i-1];
      rem_in[i] = rem_q[i-1];
      xr_in[i] = xr_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      r = {rem_in[i][H-1:0], xr_in[i][WIDTH-1 -: 2]};
      t = {root_in[i], 2'b01};
      ge = r >= t;
      root_d[i] = {root_in[i][H-2:0], ge};
      rem_d[i] = ge ? r - t : r;
      xr_d[i] = xr_in[i] << 2;
    end
  end

  assign ret = vld_q[STAGES-1];
  assign cnt_d = (bus.x_vld && !ret) ? cnt_q + 1'b1 :
                 (ret && !bus.x_vld) ? cnt_q - 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        root_q[i] <= '0;
        rem_q[i] <= '0;
        xr_q[i] <= '0;
      end
    end else begin
      vld_q <= vin;
      cnt_q <= cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        if (vin[i]) begin
          root_q[i] <= root_d[i];
          rem_q[i] <= rem_d[i];
          xr_q[i] <= xr_d[i];
        end
      end
    end
  end

  assign bus.y_vld = vld_q[STAGES-1];
  assign bus.y = root_q[STAGES-1];
  assign bus.busy = cnt_q != '0;
`ifdef ISQRT_REM_EN
  assign bus.rem = rem_q[STAGES-1][H:0];
`endif
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb_isqrt_pipe: directed and random checks of isqrt_pipe against a binary-search sqrt model.
module tb_isqrt_pipe;
  localparam int W = 32;
  localparam int STAGES = W / 2;

  typedef struct { logic v; logic [W-1:0] x; } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;

  isqrt_if #(.WIDTH(W)) bus ();
  isqrt_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic longint isqrt_ref(input longint xv);
    longint lo = 0, hi = (longint'(1) << (W / 2)) - 1, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= xv) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  ent_t   hist[$];
  logic   exp_vld = 1'b0, exp_busy = 1'b0;
  longint exp_y = 0, exp_rem = 0;

  // a result is due when the argument sampled STAGES edges ago was valid; busy while any is in flight
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      exp_vld = 1'b0;
      exp_busy = 1'b0;
      exp_y = 0;
      exp_rem = 0;
    end else begin
      hist.push_back(ent_t'{bus.x_vld, bus.x});
      if (hist.size() > STAGES) void'(hist.pop_front());
      exp_vld = hist.size() == STAGES && hist[0].v;
      if (exp_vld) begin
        exp_y = isqrt_ref(longint'(hist[0].x));
        exp_rem = longint'(hist[0].x) - exp_y * exp_y;
      end
      exp_busy = 1'b0;
      foreach (hist[i]) if (hist[i].v) exp_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("y_vld", longint'(bus.y_vld), longint'(exp_vld));
    chk("busy", longint'(bus.busy), longint'(exp_busy));
    chk("y", longint'(bus.y), exp_y);
`ifdef ISQRT_REM_EN
    chk("rem", longint'(bus.rem), exp_rem);
    if (bus.y_vld) chk("y*y+rem", longint'(bus.y) * longint'(bus.y) + longint'(bus.rem), longint'(hist[0].x));
`endif
  end

  task automatic drive(input logic v, input logic [W-1:0] xv);
    @(negedge clk);
    bus.x_vld = v;
    bus.x = xv;
  endtask

  int     pv[8];
  longint px[8], py[8], pr[8];

  // drive a short pattern, then check each output slot STAGES cycles later against literals
  task automatic seq(input int n, input bit chk_busy);
    for (int j = 0; j < n; j++) drive(pv[j] != 0, px[j][W-1:0]);
    for (int j = 0; j < STAGES - n; j++) drive(1'b0, '0);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk("lit_y_vld", longint'(bus.y_vld), longint'(pv[j]));
      chk("lit_y", longint'(bus.y), py[j]);
`ifdef ISQRT_REM_EN
      chk("lit_rem", longint'(bus.rem), pr[j]);
`endif
    end
    if (chk_busy) begin
      chk("lit_busy_last", longint'(bus.busy), 1);
      @(negedge clk);
      chk("lit_busy_drain", longint'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.x_vld = 1'b0;
    bus.x = '0;
    chk("ref_pin_24", isqrt_ref(24), 4);
    chk("ref_pin_max", isqrt_ref(64'hFFFF_FFFF), 64'hFFFF);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_y_vld", longint'(bus.y_vld), 0);
    chk("rst_y", longint'(bus.y), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    rst = 1'b0;

    pv = '{1, 1, 1, 1, 1, 0, 0, 0};
    px = '{0, 1, 15, 64'hFFFF_FFFF, 64'hFFFE_0001, 0, 0, 0};
    py = '{0, 1, 3, 64'hFFFF, 64'hFFFF, 0, 0, 0};
    pr = '{0, 0, 6, 64'h1FFFE, 0, 0, 0, 0};
    seq(5, 1'b0);
    repeat (STAGES) drive(1'b0, '0);

    pv = '{1, 1, 1, 1, 1, 1, 0, 0};
    px = '{2, 3, 4, 5, 9, 10, 0, 0};
    py = '{1, 1, 2, 2, 3, 3, 0, 0};
    pr = '{1, 2, 0, 1, 0, 1, 0, 0};
    seq(6, 1'b1);
    repeat (4) drive(1'b0, '0);

    pv = '{1, 0, 0, 1, 1, 0, 1, 0};
    px = '{16, 7, 7, 25, 100, 7, 144, 0};
    py = '{4, 4, 4, 5, 10, 10, 12, 0};
    pr = '{0, 0, 0, 0, 0, 0, 0, 0};
    seq(7, 1'b0);
    repeat (STAGES + 2) drive(1'b0, '0);

    for (int j = 0; j < 5; j++) drive(1'b1, 32'(1000 * (j + 1)));
    repeat (3) drive(1'b0, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_y_vld", longint'(bus.y_vld), 0);
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_y", longint'(bus.y), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (STAGES + 4) drive(1'b0, '0);

    pv = '{1, 0, 0, 0, 0, 0, 0, 0};
    px = '{49, 0, 0, 0, 0, 0, 0, 0};
    py = '{7, 0, 0, 0, 0, 0, 0, 0};
    pr = '{0, 0, 0, 0, 0, 0, 0, 0};
    seq(1, 1'b1);

    for (int j = 0; j < 10000; j++) begin
      int sel;
      logic [W-1:0] xv;
      sel = $urandom_range(9);
      xv = (sel == 0) ? '0 : (sel == 1) ? '1 : W'($urandom);
      drive($urandom_range(99) < 70, xv);
    end
    repeat (STAGES + 4) drive(1'b0, '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
